// File: rtl/fifoctrl_fwft_pkg.sv
// Shared constants for the FWFT FIFO controller slice.
package fifoctrl_fwft_pkg;

    // Output buffer is a head register plus one skid register.
    localparam int OBUF_ENTRIES = 2;
    localparam int OBUF_CNT_W   = $clog2(OBUF_ENTRIES + 1);

endpackage

// File: rtl/fifoctrl_fwft_if.sv
// Client-side push/pop handshake of the FWFT FIFO controller.
interface fifoctrl_fwft_if #(
    parameter int DWIDTH = 32
);
    logic              fifowr;
    logic              fiford;
    logic [DWIDTH-1:0] rddata;
    logic              rdvld;

    // Master is the FIFO user, slave is the controller.
    modport master (output fifowr, output fiford, input rddata, input rdvld);
    modport slave  (input fifowr, input fiford, output rddata, output rdvld);

endinterface

// File: rtl/fifoctrl_fwft_obuf.sv
// Two-entry head/skid output buffer; the head is always the presented word.
module fifoctrl_fwft_obuf
    import fifoctrl_fwft_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  i_load,
    input  logic [DWIDTH-1:0]     i_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [DWIDTH-1:0]     o_rddata,
    output logic                  o_rdvld,
    output logic [OBUF_CNT_W-1:0] o_outcnt
);

    logic [DWIDTH-1:0] r_head;
    logic [DWIDTH-1:0] r_skid;
    logic              r_head_vld;
    logic              r_skid_vld;
    logic              w_head_free;

    // Head is free for the arriving word if it is empty or is popped with no skid behind it.
    assign w_head_free = !r_head_vld || (i_pop && !r_skid_vld);

    // Pop advances skid into head, then an arriving word fills the first free slot.
    always_ff @(posedge clk) begin
        if (!rst_ || i_flush) begin
            r_head     <= '0;
            r_skid     <= '0;
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            if (i_pop) begin
                if (r_skid_vld) begin
                    r_head     <= r_skid;
                    r_skid_vld <= 1'b0;
                end else begin
                    r_head_vld <= 1'b0;
                end
            end
            if (i_load) begin
                if (w_head_free) begin
                    r_head     <= i_data;
                    r_head_vld <= 1'b1;
                end else begin
                    r_skid     <= i_data;
                    r_skid_vld <= 1'b1;
                end
            end
        end
    end

    assign o_rddata = r_head;
    assign o_rdvld  = r_head_vld;
    assign o_outcnt = OBUF_CNT_W'(r_head_vld) + OBUF_CNT_W'(r_skid_vld);

endmodule

// File: rtl/fifoctrl_fwft.sv
// FWFT FIFO controller for an external dual-port RAM with 1-cycle registered read.
module fifoctrl_fwft
    import fifoctrl_fwft_pkg::*;
#(
    parameter int ADDRBIT = 4,
    parameter int DEPTH   = 16,
    parameter int DWIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               i_flush,
    input  logic               i_errclr,
    input  logic [ADDRBIT+1:0] i_afthres,
    input  logic [ADDRBIT+1:0] i_aethres,
    fifoctrl_fwft_if.slave     bus,
    output logic               o_fifofull,
    output logic               o_notempty,
    output logic               o_afull,
    output logic               o_aempty,
    output logic [ADDRBIT+1:0] o_fifolen,
    output logic               o_ovf,
    output logic               o_udf,
    output logic               o_write,
    output logic [ADDRBIT-1:0] o_wraddr,
    output logic               o_read,
    output logic [ADDRBIT-1:0] o_rdaddr,
    input  logic [DWIDTH-1:0]  i_memdata
);

    localparam int                 LENW    = ADDRBIT + 2;
    localparam logic [ADDRBIT:0]   L_DEPTH = (ADDRBIT+1)'(DEPTH);
    localparam logic [ADDRBIT-1:0] L_LAST  = ADDRBIT'(DEPTH - 1);
    localparam logic [ADDRBIT-1:0] PTR_ONE = ADDRBIT'(1);
    localparam logic [ADDRBIT:0]   LEN_ONE = (ADDRBIT+1)'(1);

    logic [ADDRBIT-1:0]    r_wrptr;
    logic [ADDRBIT-1:0]    r_rdptr;
    logic [ADDRBIT:0]      r_mem_len;
    logic                  r_inflight;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_full;
    logic                  w_write;
    logic                  w_read;
    logic                  w_pop;
    logic                  w_rdvld;
    logic [DWIDTH-1:0]     w_rddata;
    logic [OBUF_CNT_W-1:0] w_outcnt;
    logic [2:0]            w_occ;
    logic [LENW-1:0]       w_fifolen;

    // Non-power-of-two depth: pointers wrap explicitly at DEPTH-1.
    function automatic logic [ADDRBIT-1:0] f_inc(input logic [ADDRBIT-1:0] p);
        return (p == L_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign w_full  = (r_mem_len == L_DEPTH);
    assign w_write = bus.fifowr && !w_full && !i_flush;
    assign w_pop   = bus.fiford && w_rdvld && !i_flush;
    // Words already owned by the buffer, counting one still coming back from RAM.
    assign w_occ   = 3'(w_outcnt) + 3'(r_inflight);
    assign w_read  = (r_mem_len != '0) && (w_occ < (3'd2 + 3'(w_pop))) && !i_flush;

    // RAM-side pointers, occupancy and read-in-flight tracking.
    always_ff @(posedge clk) begin
        if (!rst_ || i_flush) begin
            r_wrptr    <= '0;
            r_rdptr    <= '0;
            r_mem_len  <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_write) r_wrptr <= f_inc(r_wrptr);
            if (w_read)  r_rdptr <= f_inc(r_rdptr);
            r_inflight <= w_read;
            case ({w_write, w_read})
                2'b10:   r_mem_len <= r_mem_len + LEN_ONE;
                2'b01:   r_mem_len <= r_mem_len - LEN_ONE;
                default: r_mem_len <= r_mem_len;
            endcase
        end
    end

    // Sticky error flags; a new error wins over errclr and flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.fifowr && w_full)   r_ovf <= 1'b1;
            else if (i_errclr)          r_ovf <= 1'b0;
            if (bus.fiford && !w_rdvld) r_udf <= 1'b1;
            else if (i_errclr)          r_udf <= 1'b0;
        end
    end

    fifoctrl_fwft_obuf #(
        .DWIDTH (DWIDTH)
    ) u_fifo_obuf (
        .clk      (clk),
        .rst_     (rst_),
        .i_load   (r_inflight),
        .i_data   (i_memdata),
        .i_pop    (w_pop),
        .i_flush  (i_flush),
        .o_rddata (w_rddata),
        .o_rdvld  (w_rdvld),
        .o_outcnt (w_outcnt)
    );

    assign w_fifolen  = LENW'(r_mem_len) + LENW'(r_inflight) + LENW'(w_outcnt);

    assign bus.rddata = w_rddata;
    assign bus.rdvld  = w_rdvld;
    assign o_fifofull = w_full;
    assign o_notempty = (w_fifolen != '0);
    assign o_afull    = (w_fifolen >= i_afthres);
    assign o_aempty   = (w_fifolen <= i_aethres);
    assign o_fifolen  = w_fifolen;
    assign o_ovf      = r_ovf;
    assign o_udf      = r_udf;
    assign o_write    = w_write;
    assign o_wraddr   = r_wrptr;
    assign o_read     = w_read;
    assign o_rdaddr   = r_rdptr;

endmodule
